uart_rx_word: RTL
=================

UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter N, default 16, word width in bits; SHALL be a multiple of 8 (N/8 bytes per word).
REQ-002 Parameter M, default 10417, clk cycles per bit (9600 baud at 100 MHz); SHALL be at least 4.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets the block immediately).
REQ-005 serialin  input  1  asynchronous UART line, idle high.
REQ-006 clear  input  1  synchronous word-realign request; discards any partial word.
REQ-007 data_out  output  N  last completely received word.
REQ-008 valid  output  1  one-cycle pulse; data_out is new in this cycle.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-010 serialin SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-012 Word assembly: byte 0 received = data_out[7:0], byte k = data_out[8k+7:8k] (low byte first).
REQ-013 Byte FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: on synchronized 1->0 transition, go to START and load the baud counter.
REQ-015 START: after M/2 cycles, sample the line; if 0, go to DATA; if 1 (glitch), return to IDLE with no output.
REQ-016 DATA: sample every M cycles, shift the sampled bit in at the MSB of the byte register; after the 8th sample, go to STOP.
REQ-017 STOP: after M cycles, sample the line.
REQ-018 STOP sample = 1: store the byte at the current byte index and return to IDLE.
REQ-019 STOP sample = 0: pulse frame_err, reset the byte index to 0, discard the partial word, and go to IDLE; a new start SHALL NOT be detected until the line has been seen high.
REQ-020 When the stored byte completes the word (index = N/8-1):
  - data_out is updated with the full word and valid pulses high in the cycle after the stop-bit sample;
  - the byte index wraps to 0.
REQ-021 data_out SHALL hold its value until the next complete word; partial words are never visible on data_out.
REQ-022 clear=1 in any cycle: byte index := 0, FSM := IDLE, partial byte and word discarded; data_out unchanged; clear has priority over a simultaneous stop-bit sample (no valid, no frame_err).
REQ-023 valid and frame_err SHALL never be high in the same cycle.
REQ-024 Back-to-back frames with no idle bit between stop and the next start SHALL be received without loss.

Reset
REQ-025 While reset=0:
  - FSM = IDLE, baud counter = 0, bit counter = 0, byte index = 0;
  - synchronizer flops = 1;
  - data_out = 0, valid = 0, frame_err = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release, the first complete word is assembled starting from byte 0.

Structure
REQ-027 FSM state encodings and the default M constant SHALL live in the shared UART header, used by both the transmitter and this receiver.
REQ-028 One sub-module, uart_rx_byte, SHALL contain the synchronizer, byte FSM and baud/bit counters, and produce byte, byte_ok and byte_err.
REQ-029 uart_rx_word SHALL contain the byte index counter, the word register and the output pulses.

Verification (bench uses M=16, N=16)
REQ-030 Send bytes 0xDC then 0x25 with correct framing -> data_out=16'h25DC; exactly one valid pulse, one cycle after the second stop-bit sample.
REQ-031 Drive serialin low for 5 cycles in IDLE -> glitch rejected; no valid, no frame_err; a following word 0x1234 is received correctly.
REQ-032 Send byte 0xAA with stop bit 0 -> one frame_err pulse, no valid; then 0x34, 0x12 -> data_out=16'h1234.
REQ-033 Assert reset mid-DATA of the second byte -> all outputs 0; after release, 0x78, 0x56 -> data_out=16'h5678.
REQ-034 Send 3 words back-to-back with no idle bits (0x0001, 0xFFFF, 0x8000) -> three valid pulses with those values, in order.
REQ-035 Assert clear between byte 0 and byte 1 -> partial word discarded and data_out unchanged; the next two bytes 0xCD, 0xAB -> 16'hABCD.

Source files
------------

// File: rtl/uart_rx_word_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default bit period.
package uart_rx_word_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // 9600 baud from a 100 MHz clock
  localparam int UART_M_DEFAULT = 10417;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: line synchronizer, start/data/stop FSM and baud/bit down-counters.
// byte_ok / byte_err are combinational pulses in the stop-bit sample cycle.
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int M = UART_M_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serialin,
  input  logic       clear,
  output logic [7:0] byte_data,
  output logic       byte_ok,
  output logic       byte_err
);

  localparam int BW = $clog2(M);
  localparam logic [BW-1:0] HALF_LOAD = BW'(M / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(M - 1);

  rx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic          line;

  assign line      = sync_q[1];
  assign sync_d    = {sync_q[0], serialin};
  assign prev_d    = line;
  assign byte_data = shift_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
    end
  end

  // A falling edge needs prev_q high, so after a low stop bit the line must recover first
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    byte_err = 1'b0;
    if (clear) begin
      state_d = RX_IDLE;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !line) begin
            state_d = RX_START;
            baud_d  = HALF_LOAD;
          end
        end
        RX_START: begin
          if (baud_q == '0) begin
            if (!line) begin
              state_d = RX_DATA;
              baud_d  = FULL_LOAD;
              bit_d   = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            baud_d = baud_q - BW'(1);
          end
        end
        RX_DATA: begin
          if (baud_q == '0) begin
            shift_d = {line, shift_q[7:1]};
            baud_d  = FULL_LOAD;
            if (bit_q == 3'd7) begin
              state_d = RX_STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            baud_d = baud_q - BW'(1);
          end
        end
        RX_STOP: begin
          if (baud_q == '0) begin
            state_d = RX_IDLE;
            if (line) byte_ok  = 1'b1;
            else      byte_err = 1'b1;
          end else begin
            baud_d = baud_q - BW'(1);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: assembles N/8 bytes (low byte first) into data_out with
// registered valid / frame_err pulses one cycle after the stop-bit sample.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int N = 16,
  parameter int M = UART_M_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serialin,
  input  logic         clear,
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic         frame_err
);

  localparam int NB = N / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [7:0]    byte_data;
  logic          byte_ok, byte_err;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  word_q, word_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic [N-1:0]  merged;

  uart_rx_byte #(.M(M)) u_rx_byte (
    .clk       (clk),
    .reset     (reset),
    .serialin  (serialin),
    .clear     (clear),
    .byte_data (byte_data),
    .byte_ok   (byte_ok),
    .byte_err  (byte_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    merged = word_q;
    for (int k = 0; k < NB; k++) begin
      if (idx_q == IW'(k)) merged[8*k +: 8] = byte_data;
    end
  end

  // Partial bytes live in word_q; data_out only changes on a completed word
  always_comb begin
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_err) begin
      ferr_d = 1'b1;
      idx_d  = '0;
      word_d = '0;
    end else if (byte_ok) begin
      if (idx_q == LAST_IDX) begin
        data_d  = merged;
        valid_d = 1'b1;
        idx_d   = '0;
        word_d  = '0;
      end else begin
        word_d = merged;
        idx_d  = idx_q + IW'(1);
      end
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule
